draw_pair_sequencer: RTL and testbench

//   Sequences even/odd address-pair generation for the draw path. On a start

---
 rtl/draw_pair_sequencer.sv | 123 ++++++++++++
 tb/tb_draw_pair_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_pair_sequencer.sv
// Restartable even/odd address-pair sequencer for the draw path.
// Issues LEN pairs {idx,0}/{idx,1} over valid/ready; abortable at any time.
module draw_pair_sequencer #(
   parameter int ADDR_W  = 14,
   parameter int MAX_LEN = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-2:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_len,
   output logic [ADDR_W-1:0] addr_a,
   output logic [ADDR_W-1:0] addr_b,
   output logic              valid,
   input  logic              ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] pairs_done
);

   localparam int IW      = ADDR_W - 1;
   localparam int PAIRS   = 1 << IW;
   localparam int DEF_LEN = (MAX_LEN > PAIRS) ? PAIRS :
                            ((MAX_LEN < 1) ? 1 : MAX_LEN);

   localparam logic [ADDR_W-1:0] C_DEF  = ADDR_W'(DEF_LEN);
   localparam logic [ADDR_W-1:0] C_MAXP = ADDR_W'(PAIRS);
   localparam logic [ADDR_W-1:0] C_ONE  = ADDR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [IW-1:0]     r_idx;
   logic [ADDR_W-1:0] r_last;
   logic [ADDR_W-1:0] r_pairs_done;
   logic [ADDR_W-1:0] w_len_eff;
   logic              w_start_ok;
   logic              w_fire;
   logic              w_last;

   // Zero selects the default length; anything past the index space is clamped.
   always_comb begin
      w_len_eff = cfg_len;
      if (cfg_len == '0) begin
         w_len_eff = C_DEF;
      end else if (cfg_len > C_MAXP) begin
         w_len_eff = C_MAXP;
      end
   end

   assign w_start_ok = (r_state == S_IDLE) && start && !abort;
   assign w_fire     = (r_state == S_RUN) && ready && !abort;
   assign w_last     = (r_pairs_done == r_last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (abort) begin
         w_next = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: if (start) w_next = S_RUN;
            S_RUN:  if (ready && w_last) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      valid = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      unique case (r_state)
         S_IDLE: ;
         S_RUN: begin
            valid = 1'b1;
            busy  = 1'b1;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // The final handshake leaves idx alone so the outputs keep the last pair.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx        <= '0;
         r_last       <= '0;
         r_pairs_done <= '0;
      end else if (w_start_ok) begin
         r_idx        <= cfg_base;
         r_last       <= w_len_eff - C_ONE;
         r_pairs_done <= '0;
      end else if (w_fire) begin
         r_pairs_done <= r_pairs_done + C_ONE;
         if (!w_last) begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   assign addr_a     = {r_idx, 1'b0};
   assign addr_b     = {r_idx, 1'b1};
   assign pairs_done = r_pairs_done;

endmodule

// File: tb/tb_draw_pair_sequencer.sv
// Scoreboard bench for draw_pair_sequencer: directed scenarios plus
// randomized runs against a queue-based reference of expected pairs.
module tb_draw_pair_sequencer;

   localparam int AW = 14;
   localparam int IW = 13;
   localparam int NP = 8192;
   localparam int ML = 1024;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic          ready;
   logic [IW-1:0] cfg_base;
   logic [AW-1:0] cfg_len;
   logic [AW-1:0] addr_a;
   logic [AW-1:0] addr_b;
   logic          valid;
   logic          busy;
   logic          done;
   logic [AW-1:0] pairs_done;

   int n_pass = 0;
   int n_tot  = 0;

   int exp_q[$];
   bit m_run  = 1'b0;
   bit m_done = 1'b0;
   int m_cnt  = 0;

   always #5 clk = ~clk;

   draw_pair_sequencer #(.ADDR_W(AW), .MAX_LEN(ML)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .abort(abort),
      .cfg_base(cfg_base),
      .cfg_len(cfg_len),
      .addr_a(addr_a),
      .addr_b(addr_b),
      .valid(valid),
      .ready(ready),
      .busy(busy),
      .done(done),
      .pairs_done(pairs_done)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t",
                    nm, act, exp, $time);
   endtask

   // Expected run: pair indices base, base+1, ... modulo the index space.
   task automatic model_push(input int base, input int len);
      int l;
      l = (len == 0) ? ML : len;
      if (l > NP) l = NP;
      for (int k = 0; k < l; k++) exp_q.push_back((base + k) % NP);
   endtask

   // Monitor + reference: outputs checked mid-cycle, then model advanced
   // for the inputs that the next rising edge will see.
   always @(negedge clk) begin
      if (!reset) begin
         exp_q.delete();
         m_run  = 1'b0;
         m_done = 1'b0;
         m_cnt  = 0;
         chk("rst_valid", int'(valid), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_done", int'(done), 0);
         chk("rst_pairs_done", int'(pairs_done), 0);
         chk("rst_addr_a", int'(addr_a), 0);
         chk("rst_addr_b", int'(addr_b), 1);
      end else begin
         chk("valid", int'(valid), int'(m_run));
         chk("busy", int'(busy), int'(m_run | m_done));
         chk("done", int'(done), int'(m_done));
         chk("pairs_done", int'(pairs_done), m_cnt);
         if (m_run && valid) begin
            chk("addr_a", int'(addr_a), exp_q[0] * 2);
            chk("addr_b", int'(addr_b), exp_q[0] * 2 + 1);
         end
         if (abort) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            exp_q.delete();
         end else if (m_done) begin
            m_done = 1'b0;
         end else if (m_run) begin
            if (ready) begin
               void'(exp_q.pop_front());
               m_cnt++;
               if (exp_q.size() == 0) begin
                  m_run  = 1'b0;
                  m_done = 1'b1;
               end
            end
         end else if (start) begin
            model_push(int'(cfg_base), int'(cfg_len));
            m_cnt = 0;
            m_run = 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input int b, input int l);
      cfg_base = IW'(b);
      cfg_len  = AW'(l);
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string nm, input bit rnd);
      int n;
      n = 0;
      while ((busy || m_run || m_done) && n < budget) begin
         if (rnd) ready = ($urandom_range(0, 9) < 7);
         step();
         n++;
      end
      chk({nm, "_timeout"}, int'(n < budget), 1);
   endtask

   initial begin
      int seq[5];
      int n;
      reset    = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      ready    = 1'b0;
      cfg_base = '0;
      cfg_len  = '0;
      #2 reset = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();

      // 1: basic run, back-to-back acceptance
      ready = 1'b1;
      start_run(0, 4);
      wait_idle(50, "t1", 1'b0);
      chk("t1_pairs_done", int'(pairs_done), 4);

      // 2: stalls hold the pair
      ready = 1'b0;
      start_run(5, 3);
      seq = '{1, 0, 0, 1, 1};
      for (int i = 0; i < 5; i++) begin
         ready = seq[i][0];
         step();
      end
      ready = 1'b1;
      wait_idle(50, "t2", 1'b0);
      chk("t2_pairs_done", int'(pairs_done), 3);

      // 3: index wrap
      start_run(8190, 4);
      wait_idle(50, "t3", 1'b0);
      chk("t3_addr_a_last", int'(addr_a), 2);

      // 4: default length
      start_run(77, 0);
      wait_idle(1200, "t4", 1'b0);
      chk("t4_pairs_done", int'(pairs_done), 1024);

      // 5: abort with a handshake in the abort cycle
      start_run(40, 10);
      step();
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t5_valid", int'(valid), 0);
      chk("t5_done", int'(done), 0);
      chk("t5_pairs_done", int'(pairs_done), 2);
      start_run(9, 3);
      wait_idle(50, "t5b", 1'b0);
      chk("t5b_pairs_done", int'(pairs_done), 3);

      // 6: start ignored in RUN and DONE; async reset mid-run
      start_run(100, 6);
      step();
      cfg_base = 13'd7;
      cfg_len  = 14'd2;
      start    = 1'b1;
      step();
      start    = 1'b0;
      n = 0;
      while (!done && n < 50) begin
         step();
         n++;
      end
      chk("t6_done_seen", int'(done), 1);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("t6_no_restart", int'(valid), 0);
      chk("t6_pairs_done", int'(pairs_done), 6);
      start_run(0, 20);
      repeat (3) step();
      #2 reset = 1'b0;
      #1;
      chk("t6_rst_valid", int'(valid), 0);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_pairs_done", int'(pairs_done), 0);
      step();
      reset = 1'b1;
      step();
      start_run(3, 2);
      wait_idle(50, "t6b", 1'b0);
      chk("t6b_pairs_done", int'(pairs_done), 2);

      // length clamp to the index space
      start_run(1, 16383);
      wait_idle(9000, "clamp", 1'b0);
      chk("clamp_pairs_done", int'(pairs_done), NP);

      // randomized runs with stalls, aborts and stray starts
      for (int it = 0; it < 40; it++) begin
         ready = ($urandom_range(0, 9) < 7);
         start_run($urandom_range(0, NP - 1),
                   ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 24));
         n = 0;
         while ((busy || m_run || m_done) && n < 6000) begin
            ready    = ($urandom_range(0, 9) < 7);
            abort    = ($urandom_range(0, 59) == 0);
            start    = ($urandom_range(0, 9) == 0);
            cfg_base = IW'($urandom_range(0, NP - 1));
            cfg_len  = AW'($urandom_range(0, 40));
            step();
            n++;
         end
         abort = 1'b0;
         start = 1'b0;
         chk("rnd_timeout", int'(n < 6000), 1);
         repeat ($urandom_range(0, 3)) begin
            ready = $urandom_range(0, 1);
            step();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
